// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Two-requester round-robin arbiter and sequencer for the shared WIDTH-bit
//   integer logic unit (AND/OR/XOR/ADD). One operation in flight at a time:
//   IDLE grants and latches operands, EXEC computes, DONE holds a tagged
//   result until the consumer takes it.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req[1:0]          per-requester request
//   op0/a0/b0         requester 0 opcode (00 AND,01 OR,10 XOR,11 ADD), operands
//   op1/a1/b1         requester 1 opcode, operands
//   gnt[1:0]          combinational accept (IDLE only, one-hot or zero)
//   res_valid/ready   result handshake
//   res, res_id       result and owning requester
//   res_cout          ADD carry-out (0 for logic ops)
//   res_zero          res == 0
//   busy              state != IDLE
module logic_unit_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             res_id,
  output logic             res_cout,
  output logic             res_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  state_t           r_state;
  logic             r_last_id;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_id;
  logic [WIDTH-1:0] r_res;
  logic             r_res_id, r_cout, r_zero, r_valid;

  logic [1:0]       w_gnt;
  logic             w_win;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;

  // Grant only in IDLE; on a tie the requester that did not win last time goes.
  // Gated by rst_n so gnt reads 00 while reset is held, whatever req does.
  always_comb begin
    w_gnt = 2'b00;
    if (rst_n && r_state == IDLE) begin
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last_id ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_win = w_gnt[1];

  // Sum at WIDTH+1 bits so the carry falls out of the top bit.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_res = '0;
    case (r_op)
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_ADD:  w_res = w_sum[WIDTH-1:0];
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_id <= 1'b1;
      r_op      <= 2'b00;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      r_res     <= '0;
      r_res_id  <= 1'b0;
      r_cout    <= 1'b0;
      r_zero    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt != 2'b00) begin
            r_op      <= w_win ? op1 : op0;
            r_a       <= w_win ? a1  : a0;
            r_b       <= w_win ? b1  : b0;
            r_id      <= w_win;
            r_last_id <= w_win;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_res    <= w_res;
          r_cout   <= (r_op == OP_ADD) ? w_sum[WIDTH] : 1'b0;
          r_zero   <= (w_res == '0);
          r_res_id <= r_id;
          r_valid  <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          // Result fields stay put; only the handshake moves us on.
          if (res_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = w_gnt;
  assign res_valid = r_valid;
  assign res       = r_res;
  assign res_id    = r_res_id;
  assign res_cout  = r_cout;
  assign res_zero  = r_zero;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared WIDTH-bit integer logic unit (OR/AND/XOR/ADD) in the Int_ALU.
- Accepts one operation at a time, latches operands, executes in one cycle, and holds a tagged result until the consumer takes it.
- Sits between the register-read stage and the ALU result bus.

Parameters:
- WIDTH, 4, operand/result width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  request per requester; req[i] high means requester i presents an operation.
- op0  in  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 ADD.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- op1  in  2  requester 1 opcode, same encoding as op0.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- gnt  out  2  combinational accept; gnt[i] high means requester i's operation is captured at this rising edge.
- res_valid  out  1  result register holds an untaken result.
- res_ready  in  1  consumer accepts the result.
- res  out  WIDTH  registered result.
- res_id  out  1  index of the requester that owns res.
- res_cout  out  1  carry-out for ADD; 0 for the logic ops.
- res_zero  out  1  1 when res == 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; gnt = 00.
  - res_valid, res, res_id, res_cout, res_zero, busy all 0.
  - last_id = 1, so requester 0 wins the first tie.
- States: IDLE, EXEC, DONE.
- IDLE:
  - gnt is asserted only in IDLE; at most one bit of gnt is high.
  - req = 01 -> gnt = 01. req = 10 -> gnt = 10.
  - req = 11 -> grant the requester that is not last_id.
  - On any grant at the edge:
    - latch op, a, b and id of the winner; set last_id = winner.
    - next state EXEC.
  - req = 00 -> stay in IDLE.
- EXEC (one cycle):
  - Compute the result on the latched operands:
    - AND -> a&b; OR -> a|b; XOR -> a^b.
    - ADD -> {cout, res} = a + b, computed at WIDTH+1 bits; the sum wraps modulo 2^WIDTH.
  - Register res, res_cout, res_zero and res_id; set res_valid = 1; next state DONE.
- DONE:
  - Hold res, res_id, res_cout, res_zero and res_valid stable while res_ready = 0.
  - res_ready = 1 at an edge -> res_valid = 0, next state IDLE.
  - No new grant is issued in the same cycle; there is always at least one idle cycle between transactions.
  - res_ready is ignored in IDLE and EXEC.
- Latency:
  - Request seen with gnt high in cycle N.
  - res_valid high from cycle N+2.
  - With res_ready held high, the next grant comes no earlier than cycle N+3, so peak throughput is one operation per 3 cycles.
- Operand stability: requesters need to hold inputs valid only in the gnt cycle. Input changes after capture do not affect the result.
- Fairness: under continuous req = 11, grants alternate 0,1,0,1,...
- Requesters drop req after their gnt; a held req is treated as a new request in the next IDLE cycle.
- Reset mid-operation (rst_n low in EXEC or DONE): any pending result is discarded, all outputs return to reset values immediately, and last_id returns to 1.
- The arbiter retains no other state across reset.

Test Plan:
- Reset defaults: hold rst_n = 0 for 2 cycles, then release -> res_valid = 0, gnt = 00, busy = 0, res = 0000.
- Single OR: req = 01, op0 = 01, a0 = 1111, b0 = 0000, res_ready = 1.
  - gnt = 01 in the request cycle.
  - Two cycles later: res_valid = 1, res = 1111, res_id = 0, res_zero = 0, res_cout = 0.
- ADD wrap and zero flag: req = 10, op1 = 11, a1 = 1001, b1 = 0111 -> res = 0000, res_cout = 1, res_zero = 1, res_id = 1.
- Round-robin under contention, req held at 11 with res_ready = 1 throughout:
  - requester 0 runs XOR 0110^0011; requester 1 runs AND 0110&0011.
  - Grants alternate 01, 10, 01.
  - Results in order: 0101 with id 0, then 0010 with id 1.
- Backpressure: keep res_ready = 0 for 5 cycles after res_valid rises.
  - res and res_id stay stable; busy = 1; gnt = 00 despite req = 11.
  - Raise res_ready -> res_valid drops next edge and a grant follows in the IDLE cycle.
- Reset mid-operation: pull rst_n low during EXEC -> res_valid = 0 and busy = 0 immediately. After release, req = 11 grants requester 0 first.
